conv_encoder: RTL and testbench
===============================

# conv_encoder

Rate-1/2, constraint-length-3 convolutional encoder; the transmit-side counterpart of the Viterbi decoder's branch-metric stage. It accepts a frame of serial data bits through a valid/ready handshake and emits one 2-bit code symbol per input bit. Code symbols use the bit order the decoder's Hamming-distance table expects: state 0 with input 1 produces 11. Symbols are presented on a registered, back-pressurable output. Optionally, trellis-terminating tail symbols follow each frame.

## Interface
- FRAME_LEN, 16: data bits per frame, ≥1
- G0, 3'b111: generator for o_Tx[1], bit order {current, prev1, prev2}
- G1, 3'b101: generator for o_Tx[0], same bit order
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- en_encode  input  1  frame start request, sampled only in IDLE
- i_data  input  1  data bit
- i_valid  input  1  i_data valid
- o_ready  output  1  encoder accepts i_data this cycle
- o_Tx  output  2  code symbol {G0 parity, G1 parity}
- o_valid  output  1  o_Tx valid
- i_ready  input  1  downstream accepts o_Tx
- o_last  output  1  marks the final symbol of the frame, qualified by o_valid
- o_busy  output  1  high while a frame is in progress

## Operation
- Shift state sr[1:0]: sr[1] holds prev1 and sr[0] holds prev2. It is cleared to 00 at every frame start.
- Encoding window: w = {b, sr[1], sr[0]}.
  - o_Tx[1] = ^(w & G0)
  - o_Tx[0] = ^(w & G1)
  - After each encoded bit, sr <= {b, sr[1]}.
- FSM states: IDLE, ENCODE, FLUSH.
  - IDLE to ENCODE: en_encode=1. Clears sr and the bit counter.
  - ENCODE: a bit is consumed on i_valid && o_ready. The counter increments per accepted bit. After bit FRAME_LEN is accepted, go to FLUSH if tail is enabled, else IDLE.
  - FLUSH: encode b=0 twice, each time the output register is free. Then go to IDLE.
- o_ready = (state==ENCODE) && (!o_valid || i_ready).
- o_busy = (state != IDLE) || o_valid.
- Output register handshake:
  - It loads on a consumed bit or a generated tail symbol.
  - It holds o_Tx, o_valid and o_last stable while o_valid && !i_ready.
  - o_valid clears on an i_ready handshake when no new symbol loads in the same cycle.
- o_last is set with the last symbol of the frame:
  - the second tail symbol when tail is enabled;
  - the FRAME_LEN-th data symbol when tail is disabled.
- en_encode is ignored outside IDLE. Deasserting it mid-frame has no effect.
- The bit counter is $clog2(FRAME_LEN+1) bits wide. It never wraps within a frame.

## Timing
- Reset (asynchronous assert) sets:
  - o_Tx=00, o_valid=0, o_last=0, o_ready=0, o_busy=0
  - sr=00, counter=0, state=IDLE
- Latency: a bit accepted in cycle N gives o_valid=1 with its symbol in cycle N+1.
- Throughput: 1 symbol/cycle under continuous i_valid and i_ready.
- Simultaneous drain and load (o_valid && i_ready && new symbol): the register reloads and o_valid stays 1 with no bubble.
- en_encode in cycle N: o_ready can first be 1 in cycle N+1.
- After the final handshake, o_busy falls in the same cycle that o_valid falls. A new en_encode is accepted in that cycle or later.
- Reset mid-frame:
  - Immediate return to IDLE.
  - Any pending symbol is dropped.
  - No partial tail is emitted.

## Configuration
- CONV_ENC_TAIL_EN defined:
  - FLUSH state present; 2 zero-input tail symbols follow each frame.
  - The frame is FRAME_LEN+2 symbols and ends in state 00.
- Undefined:
  - FLUSH removed; the frame is FRAME_LEN symbols.
  - The trellis is left unterminated and the decoder must trace back from the best metric.

## Structure
- Shared package conv_pkg holds:
  - K=3, default G0/G1 constants;
  - the symbol width (2);
  - the FSM state typedef (IDLE/ENCODE/FLUSH).
- One sub-module, conv_parity: combinational window to 2-bit symbol, parameterised by G0/G1.
  - It is reused by the decoder's test model to generate expected branch labels.

## Test plan
- FRAME_LEN=4, tail enabled, i_data 1,0,1,1, i_ready=1:
  - o_Tx = 11,10,00,01,01,11
  - o_last only on the 6th symbol; o_busy falls after it.
- Same stimulus with CONV_ENC_TAIL_EN undefined:
  - o_Tx = 11,10,00,01
  - o_last on the 4th symbol.
- Backpressure: hold i_ready=0 for 3 cycles after the first symbol:
  - o_Tx=11 is held stable with o_valid=1 and o_ready=0.
  - The stream resumes with no lost or duplicated symbol.
- Input gaps: toggle i_valid 1,0,0,1 with continuous i_ready:
  - Symbols appear exactly one cycle after each accepted bit.
  - The sequence is identical to the gap-free run.
- Assert rst mid-frame after 2 symbols:
  - All outputs return to their reset values asynchronously.
  - The next frame from 1,0,1,1 reproduces 11,10,00,01 (sr cleared).
- en_encode pulsed during ENCODE and FLUSH: no restart; the counter and symbol stream are unaffected.

Source files
------------

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared constants and types for the rate-1/2, K=3
//               convolutional encoder and its companion parity block.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    // Constraint length: current bit plus two bits of history.
    localparam int c_k     = 3;

    // One code symbol carries two parity bits.
    localparam int c_sym_w = 2;

    // Default generators, bit order {current, prev1, prev2}.
    localparam logic [c_k-1:0] c_g0_default = 3'b111;
    localparam logic [c_k-1:0] c_g1_default = 3'b101;

    // Encoder control state, explicitly two bits wide.
    typedef logic [1:0] conv_state_t;

    localparam conv_state_t c_st_idle   = 2'd0;
    localparam conv_state_t c_st_encode = 2'd1;
    localparam conv_state_t c_st_flush  = 2'd2;

endpackage : conv_pkg
`default_nettype wire

// File: rtl/conv_parity.sv
`default_nettype none
// ============================================================================
// Module      : conv_parity
// Description : Combinational K=3 window to 2-bit code symbol. The window
//               is {current, prev1, prev2}; the symbol is
//               {parity(window & G0), parity(window & G1)}. Also used by the
//               decoder's test model to generate expected branch labels.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_parity
    import conv_pkg::*;
#(
    parameter logic [c_k-1:0] G0 = c_g0_default,
    parameter logic [c_k-1:0] G1 = c_g1_default
) (
    input  logic [c_k-1:0]     i_window,
    output logic [c_sym_w-1:0] o_sym
);

    // Each symbol bit is the XOR of the window bits selected by its generator.
    always_comb begin
        o_sym = {^(i_window & G0), ^(i_window & G1)};
    end

endmodule : conv_parity
`default_nettype wire

// File: rtl/conv_encoder.sv
`default_nettype none
// ============================================================================
// Module      : conv_encoder
// Description : Rate-1/2, constraint-length-3 convolutional encoder. Accepts
//               a frame of FRAME_LEN serial bits over a valid/ready handshake
//               and emits one 2-bit code symbol per bit on a registered,
//               back-pressurable output. A symbol for a bit accepted in
//               cycle N is presented in cycle N+1.
//               Build option CONV_ENC_TAIL_EN: when defined, two zero-input
//               tail symbols terminate the trellis after every frame (frame
//               length FRAME_LEN+2, ending in state 00). When undefined the
//               frame is FRAME_LEN symbols and the trellis is unterminated.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_encoder
    import conv_pkg::*;
#(
    parameter int              FRAME_LEN = 16,
    parameter logic [c_k-1:0]  G0        = c_g0_default,
    parameter logic [c_k-1:0]  G1        = c_g1_default
) (
    input  logic                clk,
    input  logic                rst,        // asynchronous, active-low
    input  logic                en_encode,
    input  logic                i_data,
    input  logic                i_valid,
    output logic                o_ready,
    output logic [c_sym_w-1:0]  o_Tx,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_last,
    output logic                o_busy
);

    // Counter is wide enough to hold FRAME_LEN itself so it never wraps.
    localparam int                 c_cnt_w    = $clog2(FRAME_LEN + 1);
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(FRAME_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    conv_state_t          r_state;
    conv_state_t          w_state_nxt;
    logic [1:0]           r_sr;          // {prev1, prev2}
    logic [1:0]           w_sr_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;

`ifdef CONV_ENC_TAIL_EN
    // Which of the two tail symbols is generated next.
    logic                 r_tail_idx;
    logic                 w_tail_idx_nxt;
`endif

    // Output register.
    logic [c_sym_w-1:0]   r_tx;
    logic                 r_valid;
    logic                 r_last;

    // ------------------------------------------------------------------------
    // Datapath control
    // ------------------------------------------------------------------------
    logic                 w_out_free;    // output register may take a symbol
    logic                 w_accept;      // input bit consumed this cycle
    logic                 w_tail_gen;    // tail symbol generated this cycle
    logic                 w_load;
    logic                 w_last_sym;
    logic                 w_bit;
    logic [c_k-1:0]       w_window;
    logic [c_sym_w-1:0]   w_sym;

    assign w_out_free = !r_valid || i_ready;
    assign w_accept   = (r_state == c_st_encode) && i_valid && w_out_free;

`ifdef CONV_ENC_TAIL_EN
    assign w_tail_gen = (r_state == c_st_flush) && w_out_free;
    assign w_last_sym = w_tail_gen && r_tail_idx;
`else
    assign w_tail_gen = 1'b0;
    assign w_last_sym = w_accept && (r_cnt == c_last_idx);
`endif

    assign w_load   = w_accept || w_tail_gen;

    // Tail symbols encode a forced zero input.
    assign w_bit    = (r_state == c_st_encode) ? i_data : 1'b0;
    assign w_window = {w_bit, r_sr};

    conv_parity #(
        .G0 (G0),
        .G1 (G1)
    ) u_parity (
        .i_window (w_window),
        .o_sym    (w_sym)
    );

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------

    // Control state register: frame state, shift history and bit counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_st_idle;
            r_sr       <= 2'b00;
            r_cnt      <= '0;
`ifdef CONV_ENC_TAIL_EN
            r_tail_idx <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_sr       <= w_sr_nxt;
            r_cnt      <= w_cnt_nxt;
`ifdef CONV_ENC_TAIL_EN
            r_tail_idx <= w_tail_idx_nxt;
`endif
        end
    end

    // Next-state logic: frame start, per-bit shift/count and tail sequencing.
    always_comb begin
        w_state_nxt    = r_state;
        w_sr_nxt       = r_sr;
        w_cnt_nxt      = r_cnt;
`ifdef CONV_ENC_TAIL_EN
        w_tail_idx_nxt = r_tail_idx;
`endif
        case (r_state)
            c_st_idle: begin
                // en_encode only matters here; every frame starts from state 00.
                if (en_encode) begin
                    w_state_nxt = c_st_encode;
                    w_sr_nxt    = 2'b00;
                    w_cnt_nxt   = '0;
                end
            end
            c_st_encode: begin
                if (w_accept) begin
                    w_sr_nxt  = {i_data, r_sr[1]};
                    w_cnt_nxt = r_cnt + c_cnt_one;
                    if (r_cnt == c_last_idx) begin
`ifdef CONV_ENC_TAIL_EN
                        w_state_nxt    = c_st_flush;
                        w_tail_idx_nxt = 1'b0;
`else
                        w_state_nxt    = c_st_idle;
`endif
                    end
                end
            end
`ifdef CONV_ENC_TAIL_EN
            c_st_flush: begin
                // Two zero inputs push the history back to state 00.
                if (w_tail_gen) begin
                    w_sr_nxt       = {1'b0, r_sr[1]};
                    w_tail_idx_nxt = 1'b1;
                    if (r_tail_idx) begin
                        w_state_nxt = c_st_idle;
                    end
                end
            end
`endif
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------------

    // Load on a new symbol; otherwise drain on handshake, hold while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx    <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_load) begin
            r_tx    <= w_sym;
            r_valid <= 1'b1;
            r_last  <= w_last_sym;
        end else if (i_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign o_Tx    = r_tx;
    assign o_valid = r_valid;
    assign o_last  = r_last;
    assign o_ready = (r_state == c_st_encode) && w_out_free;
    assign o_busy  = (r_state != c_st_idle) || r_valid;

endmodule : conv_encoder
`default_nettype wire

// File: tb/tb_conv_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_encoder
// Description : Scoreboard bench for conv_encoder (FRAME_LEN=4). Stimulus
//               pushes expected {symbol, last} entries into a queue; a
//               monitor pops and compares on every output handshake.
//               Honours CONV_ENC_TAIL_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_encoder;

    localparam int FRAME_LEN = 4;
`ifdef CONV_ENC_TAIL_EN
    localparam int TAIL = 2;
`else
    localparam int TAIL = 0;
`endif
    localparam int         NSYM = FRAME_LEN + TAIL;
    localparam logic [2:0] G0   = 3'b111;
    localparam logic [2:0] G1   = 3'b101;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       en_encode = 1'b0;
    logic       i_data    = 1'b0;
    logic       i_valid   = 1'b0;
    logic       i_ready   = 1'b1;
    logic       o_ready;
    logic [1:0] o_Tx;
    logic       o_valid;
    logic       o_last;
    logic       o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] exp_q[$];            // {o_Tx, o_last}
    logic [2:0] cur_exp [NSYM];      // expected symbols of the current frame

    int cyc         = 0;
    int stall_pct   = 0;
    int stall_start = -100;
    int stall_len   = 0;

    logic       held_v = 1'b0;
    logic [2:0] held   = 3'b000;

    conv_encoder #(
        .FRAME_LEN (FRAME_LEN),
        .G0        (G0),
        .G1        (G1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en_encode (en_encode),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_Tx      (o_Tx),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_last    (o_last),
        .o_busy    (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: code sequence as a convolution over the bit list,
    // with zero history before the frame and zero tail inputs after it.
    task automatic build_expected(input logic [FRAME_LEN-1:0] bits);
        int x [NSYM + 2];
        int g0;
        int g1;
        int s0;
        int s1;
        g0 = int'(G0);
        g1 = int'(G1);
        x[0] = 0;
        x[1] = 0;
        for (int i = 0; i < NSYM; i++) begin
            x[i + 2] = (i < FRAME_LEN) ? int'(bits[i]) : 0;
        end
        for (int i = 0; i < NSYM; i++) begin
            s0 = (((g0 >> 2) & 1) * x[i + 2] + ((g0 >> 1) & 1) * x[i + 1] + (g0 & 1) * x[i]) % 2;
            s1 = (((g1 >> 2) & 1) * x[i + 2] + ((g1 >> 1) & 1) * x[i + 1] + (g1 & 1) * x[i]) % 2;
            cur_exp[i] = {s0 == 1, s1 == 1, i == NSYM - 1};
        end
    endtask

    // Downstream ready driver: random stalls plus an optional forced window.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc >= stall_start && cyc < stall_start + stall_len) begin
                i_ready = 1'b0;
            end else if (stall_pct > 0) begin
                i_ready = ($urandom_range(99) >= stall_pct);
            end else begin
                i_ready = 1'b1;
            end
        end
    end

    // Monitor: compare on each handshake, and check stalled output stays put.
    always @(negedge clk) begin
        logic [2:0] e;
        if (rst) begin
            if (held_v) begin
                check("stall_hold", 32'({o_valid, o_Tx, o_last}), 32'({1'b1, held}));
            end
            if (o_valid) begin
                if (i_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_symbol: got %0b, required none (t=%0t)", {o_Tx, o_last}, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("symbol", 32'({o_Tx, o_last}), 32'(e));
                    end
                    held_v = 1'b0;
                end else begin
                    check("ready_in_stall", 32'(o_ready), 32'(1'b0));
                    held_v = 1'b1;
                    held   = {o_Tx, o_last};
                end
            end else begin
                held_v = 1'b0;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx"},    32'(o_Tx),    32'(2'b00));
        check({tag, "_valid"}, 32'(o_valid), 32'(1'b0));
        check({tag, "_last"},  32'(o_last),  32'(1'b0));
        check({tag, "_ready"}, 32'(o_ready), 32'(1'b0));
        check({tag, "_busy"},  32'(o_busy),  32'(1'b0));
    endtask

    // One frame. Called and returns at posedge+1 with the encoder idle.
    task automatic run_frame(input logic [FRAME_LEN-1:0] bits, input int gap_pct,
                             input bit en_noise, input int abort_after, input bit stall_first);
        int t;
        for (int i = 0; i < NSYM; i++) exp_q.push_back(cur_exp[i]);
        en_encode = 1'b1;
        @(posedge clk);
        #1;
        en_encode = 1'b0;
        check("ready_after_start", 32'(o_ready), 32'(1'b1));
        for (int i = 0; i < FRAME_LEN; i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                i_valid   = 1'b0;
                i_data    = 1'($urandom_range(1));
                en_encode = en_noise ? 1'($urandom_range(1)) : 1'b0;
                @(posedge clk);
                #1;
            end
            i_valid   = 1'b1;
            i_data    = bits[i];
            en_encode = en_noise ? 1'($urandom_range(1)) : 1'b0;
            t = 0;
            forever begin
                @(negedge clk);
                if (o_ready) break;
                t++;
                if (t > 200) break;
            end
            if (t > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: bit %0d not accepted, required acceptance within 200 cycles", i);
                i_valid   = 1'b0;
                en_encode = 1'b0;
                return;
            end
            if (stall_first && i == 0) begin
                stall_start = cyc + 1;
                stall_len   = 3;
            end
            @(posedge clk);
            #1;
            i_valid   = 1'b0;
            en_encode = 1'b0;
            check("latency_valid", 32'(o_valid), 32'(1'b1));
            check("latency_sym", 32'({o_Tx, o_last}), 32'(cur_exp[i]));
            if (abort_after == i + 1) begin
                #2;
                rst = 1'b0;
                #1;
                check_reset_outputs("async_reset");
                exp_q.delete();
                @(negedge clk);
                rst = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
        end
        if (TAIL > 0 && en_noise) begin
            en_encode = 1'b1;
            @(posedge clk);
            #1;
            en_encode = 1'b0;
        end
        t = 0;
        forever begin
            @(negedge clk);
            if (!o_busy) break;
            t++;
            if (t > 300) break;
        end
        if (t > 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL busy_timeout: o_busy still 1, required 0 within 300 cycles");
        end
        check("frame_drained", 32'(exp_q.size()), 32'(0));
        check("idle_valid", 32'(o_valid), 32'(1'b0));
        check("idle_ready", 32'(o_ready), 32'(1'b0));
        @(posedge clk);
        #1;
    endtask

    task automatic load_directed();
`ifdef CONV_ENC_TAIL_EN
        cur_exp[0] = 3'b110;
        cur_exp[1] = 3'b100;
        cur_exp[2] = 3'b000;
        cur_exp[3] = 3'b010;
        cur_exp[4] = 3'b010;
        cur_exp[5] = 3'b111;
`else
        cur_exp[0] = 3'b110;
        cur_exp[1] = 3'b100;
        cur_exp[2] = 3'b000;
        cur_exp[3] = 3'b011;
`endif
    endtask

    initial begin
        logic [FRAME_LEN-1:0] dir_bits;
        logic [FRAME_LEN-1:0] rb;
        dir_bits = 4'b1101;   // sent LSB first: 1,0,1,1

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Known vector, no gaps, no stalls.
        load_directed();
        run_frame(dir_bits, 0, 1'b0, 0, 1'b0);

        // Three-cycle backpressure on the first symbol.
        load_directed();
        run_frame(dir_bits, 0, 1'b0, 0, 1'b1);

        // Input gaps.
        load_directed();
        run_frame(dir_bits, 50, 1'b0, 0, 1'b0);

        // Reset after two symbols, then the same frame again from clean state.
        load_directed();
        run_frame(dir_bits, 0, 1'b0, 2, 1'b0);
        load_directed();
        run_frame(dir_bits, 0, 1'b0, 0, 1'b0);

        // en_encode noise during the frame.
        load_directed();
        run_frame(dir_bits, 30, 1'b1, 0, 1'b0);

        // Random frames against the model.
        for (int f = 0; f < 24; f++) begin
            rb        = FRAME_LEN'($urandom);
            stall_pct = $urandom_range(0, 60);
            build_expected(rb);
            run_frame(rb, $urandom_range(0, 50), (f % 2) == 1, 0, 1'b0);
        end
        stall_pct = 0;
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_conv_encoder
`default_nettype wire
